// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_pkg
//  Description : Shared definitions for the system-bus SRAM responder:
//                responder state encoding and bus field widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package bus_pkg;

    localparam int c_data_w      = 32;  // multiplexed address/data bus width
    localparam int c_be_w        = 4;   // byte lanes per bus word
    localparam int c_burst_w     = 8;   // burst length field (beats minus one)
    localparam int c_beat_cnt_w  = 9;   // counts up to 256 transferred beats

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WRITE      = 3'd1,
        ST_READ_FETCH = 3'd2,
        ST_READ       = 3'd3,
        ST_READ_END   = 3'd4,
        ST_ERROR      = 3'd5
    } bus_state_t;

endpackage : bus_pkg
`default_nettype wire

// File: rtl/bus_sram_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : bus_sram_responder_if
//  Description : System-bus signal bundle between an initiator (master) and
//                the SRAM responder (slave). Outputs of every agent are
//                wired-OR on the real bus, so idle agents drive zeros.
//  Ports       : begin_transactionIN, address_dataIN, byte_enableIN,
//                burst_sizeIN, read_n_writeIN, end_transactionIN,
//                data_validIN, busyIN          (initiator -> responder)
//                address_dataOUT, end_transactionOUT, data_validOUT,
//                busyOUT, errorOUT             (responder -> initiator)
//  Revision    : 1.0 - initial release
// ============================================================================
interface bus_sram_responder_if;
    import bus_pkg::*;

    logic                  begin_transactionIN;
    logic [c_data_w-1:0]   address_dataIN;
    logic [c_be_w-1:0]     byte_enableIN;
    logic [c_burst_w-1:0]  burst_sizeIN;
    logic                  read_n_writeIN;
    logic                  end_transactionIN;
    logic                  data_validIN;
    logic                  busyIN;

    logic [c_data_w-1:0]   address_dataOUT;
    logic                  end_transactionOUT;
    logic                  data_validOUT;
    logic                  busyOUT;
    logic                  errorOUT;

    modport slave (
        input  begin_transactionIN, address_dataIN, byte_enableIN,
               burst_sizeIN, read_n_writeIN, end_transactionIN,
               data_validIN, busyIN,
        output address_dataOUT, end_transactionOUT, data_validOUT,
               busyOUT, errorOUT
    );

    modport master (
        output begin_transactionIN, address_dataIN, byte_enableIN,
               burst_sizeIN, read_n_writeIN, end_transactionIN,
               data_validIN, busyIN,
        input  address_dataOUT, end_transactionOUT, data_validOUT,
               busyOUT, errorOUT
    );

endinterface : bus_sram_responder_if
`default_nettype wire

// File: rtl/sram_be.sv
`default_nettype none
// ============================================================================
//  Module      : sram_be
//  Description : Single-port synchronous word RAM with per-byte write
//                enables. One-cycle read latency; a read during a write to
//                the same word returns the old contents.
//  Ports       : clk     - clock
//                i_addr  - word address
//                i_we    - per-byte write enables
//                i_wdata - write data
//                o_rdata - registered read data
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_be
    import bus_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic [c_be_w-1:0]   i_we,
    input  logic [c_data_w-1:0] i_wdata,
    output logic [c_data_w-1:0] o_rdata
);

    logic [c_data_w-1:0] r_mem [DEPTH];
    logic [c_data_w-1:0] r_rdata;

    always_ff @(posedge clk) begin
        for (int b = 0; b < c_be_w; b++) begin
            if (i_we[b]) begin
                r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;

endmodule : sram_be
`default_nettype wire

// File: rtl/bus_sram_responder.sv
`default_nettype none
// ============================================================================
//  Module      : bus_sram_responder
//  Description : Burst-capable system-bus responder backed by an internal
//                byte-enabled SRAM. Decodes the window
//                [BASE_ADDRESS, BASE_ADDRESS + 4*SIZE_WORDS), serves single
//                and burst reads/writes with a wrapping word index, and
//                answers out-of-window accesses with a one-cycle error.
//  Ports       : system_clock - clock
//                system_reset - synchronous active-high reset
//                bus          - bus_sram_responder_if.slave bundle
//  Options     : BUS_SRAM_WAIT_STATE_EN - when defined, the first write
//                cycle is stalled with busyOUT and the read fetch takes two
//                cycles, to exercise initiator stall handling.
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_sram_responder
    import bus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
    parameter int          SIZE_WORDS   = 1024
) (
    input  logic                  system_clock,
    input  logic                  system_reset,
    bus_sram_responder_if.slave   bus
);

    localparam int c_idx_w = $clog2(SIZE_WORDS);

`ifdef BUS_SRAM_WAIT_STATE_EN
    localparam logic c_wait_en = 1'b1;
`else
    localparam logic c_wait_en = 1'b0;
`endif

    bus_state_t               r_state;
    logic [c_idx_w-1:0]       r_index;   // word index of the current beat
    logic [c_burst_w-1:0]     r_burst;
    logic [c_beat_cnt_w-1:0]  r_count;   // beats transferred so far
    logic                     r_dv;
    logic                     r_eot;
    logic                     r_err;
    logic                     r_busy;
    logic                     r_wait;    // extra fetch cycle pending

    logic                     w_hit;
    logic [c_idx_w-1:0]       w_begin_index;
    logic                     w_in_range;
    logic                     w_last_beat;
    logic                     w_wr_accept;
    logic                     w_rd_advance;
    logic [c_idx_w-1:0]       w_ram_addr;
    logic [c_be_w-1:0]        w_ram_we;
    logic [c_data_w-1:0]      w_ram_rdata;

    // The window is aligned to its own size, so a hit is an exact match of
    // the bits above the word index, and the index is the bits below it.
    assign w_hit         = (bus.address_dataIN[31:c_idx_w+2] == BASE_ADDRESS[31:c_idx_w+2]);
    assign w_begin_index = bus.address_dataIN[c_idx_w+1:2];

    assign w_in_range   = (r_count <= {1'b0, r_burst});
    assign w_last_beat  = (r_count == {1'b0, r_burst});

    // Write beats past the burst length are silently dropped; reset also
    // blocks the RAM so a mid-burst reset leaves its contents alone.
    assign w_wr_accept  = (r_state == ST_WRITE) && bus.data_validIN && !r_busy
                          && w_in_range && !system_reset;
    assign w_rd_advance = (r_state == ST_READ) && !bus.busyIN;

    // When a read beat transfers, the following word is addressed in the
    // same cycle so it is on the RAM output for the next beat; while the
    // initiator stalls, the same word is re-read and the output holds.
    assign w_ram_addr = w_rd_advance ? (r_index + 1'b1) : r_index;
    assign w_ram_we   = w_wr_accept  ? bus.byte_enableIN : '0;

    sram_be #(
        .DEPTH (SIZE_WORDS)
    ) u_sram (
        .clk     (system_clock),
        .i_addr  (w_ram_addr),
        .i_we    (w_ram_we),
        .i_wdata (bus.address_dataIN),
        .o_rdata (w_ram_rdata)
    );

    always_ff @(posedge system_clock) begin
        if (system_reset) begin
            r_state <= ST_IDLE;
            r_index <= '0;
            r_burst <= '0;
            r_count <= '0;
            r_dv    <= 1'b0;
            r_eot   <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_wait  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.begin_transactionIN) begin
                        r_index <= w_begin_index;
                        r_burst <= bus.burst_sizeIN;
                        r_count <= '0;
                        if (!w_hit) begin
                            r_state <= ST_ERROR;
                            r_err   <= 1'b1;
                            r_eot   <= 1'b1;
                        end else if (bus.read_n_writeIN) begin
                            r_state <= ST_READ_FETCH;
                            r_wait  <= c_wait_en;
                        end else begin
                            r_state <= ST_WRITE;
                            r_busy  <= c_wait_en;
                        end
                    end
                end

                ST_WRITE: begin
                    r_busy <= 1'b0;
                    if (w_wr_accept) begin
                        r_index <= r_index + 1'b1;
                        r_count <= r_count + 1'b1;
                    end
                    if (bus.end_transactionIN) begin
                        r_state <= ST_IDLE;
                    end
                end

                ST_READ_FETCH: begin
                    if (bus.end_transactionIN) begin
                        r_state <= ST_IDLE;
                        r_wait  <= 1'b0;
                    end else if (r_wait) begin
                        r_wait <= 1'b0;
                    end else begin
                        r_state <= ST_READ;
                        r_dv    <= 1'b1;
                    end
                end

                ST_READ: begin
                    // An initiator abort wins over a same-cycle transfer and
                    // ends the read without end_transactionOUT.
                    if (bus.end_transactionIN) begin
                        r_state <= ST_IDLE;
                        r_dv    <= 1'b0;
                    end else if (w_rd_advance) begin
                        r_index <= r_index + 1'b1;
                        r_count <= r_count + 1'b1;
                        if (w_last_beat) begin
                            r_state <= ST_READ_END;
                            r_dv    <= 1'b0;
                            r_eot   <= 1'b1;
                        end
                    end
                end

                ST_READ_END: begin
                    r_eot   <= 1'b0;
                    r_state <= ST_IDLE;
                end

                ST_ERROR: begin
                    r_err   <= 1'b0;
                    r_eot   <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_dv    <= 1'b0;
                    r_eot   <= 1'b0;
                    r_err   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_wait  <= 1'b0;
                end
            endcase
        end
    end

    // The bus is wired-OR: data is forced to zero outside read beats.
    assign bus.address_dataOUT    = r_dv ? w_ram_rdata : '0;
    assign bus.data_validOUT      = r_dv;
    assign bus.end_transactionOUT = r_eot;
    assign bus.busyOUT            = r_busy;
    assign bus.errorOUT           = r_err;

endmodule : bus_sram_responder
`default_nettype wire

// File: doc/bus_sram_responder.md
# bus_sram_responder

Burst-capable responder (slave) on the system bus driven by the JTAG bus initiator and other masters. It decodes a fixed address window, serves single and burst reads/writes from an internal word-wide SRAM with byte enables, and signals decode errors. It sits behind the arbiter, on the same multiplexed address/data bus as the initiators.

## Interface
- BASE_ADDRESS, 32'h0000_0000, byte address of window start; aligned to 4*SIZE_WORDS
- SIZE_WORDS, 1024, SRAM depth in 32-bit words; power of two, 16..65536
- system_clock  in  1  single clock for all logic
- system_reset  in  1  synchronous, active-high reset
- begin_transactionIN  in  1  one-cycle start strobe; address/command valid this cycle
- address_dataIN  in  32  byte address on begin cycle, write data on write beats
- byte_enableIN  in  4  byte lanes, sampled on each accepted write beat
- burst_sizeIN  in  8  beats minus one, sampled on begin cycle
- read_n_writeIN  in  1  1 = read, 0 = write, sampled on begin cycle
- end_transactionIN  in  1  initiator ends write, or aborts read
- data_validIN  in  1  write beat valid
- busyIN  in  1  initiator stalls read beats
- address_dataOUT  out  32  read data; zero when not driving a beat
- end_transactionOUT  out  1  responder ends read or error transaction
- data_validOUT  out  1  read beat valid
- busyOUT  out  1  responder stalls write beats
- errorOUT  out  1  decode error strobe

## Operation
- All outputs are zero in reset and whenever not active (bus is wired-OR).
- States: IDLE, WRITE, READ_FETCH, READ, READ_END, ERROR.
- IDLE: on begin_transactionIN, register address, burst_sizeIN, read_n_writeIN. Hit = address in [BASE_ADDRESS, BASE_ADDRESS+4*SIZE_WORDS). Miss -> ERROR; hit read -> READ_FETCH; hit write -> WRITE.
- Word index = (address - BASE_ADDRESS) >> 2; address bits [1:0] ignored. Index increments by 1 per transferred beat, wrapping modulo SIZE_WORDS.
- WRITE: beat accepted when data_validIN=1 and busyOUT=0; lanes with byte_enableIN=1 written. Beats beyond burst_size+1 ignored. end_transactionIN -> IDLE (same-cycle beat still written).
- READ_FETCH: issue synchronous RAM read -> READ.
- READ: drive data_validOUT=1 and word. Beat transfers when busyIN=0; while busyIN=1, word and data_validOUT held. Next word prefetched so consecutive beats are back-to-back. After beat burst_size+1 transfers -> READ_END.
- READ_END: end_transactionOUT=1 for one cycle -> IDLE.
- ERROR: errorOUT=1 and end_transactionOUT=1 for one cycle -> IDLE. No RAM access.
- end_transactionIN in READ_FETCH/READ: abort, -> IDLE next cycle, no end_transactionOUT.
- begin_transactionIN outside IDLE is ignored (arbiter guarantees exclusivity).
- Reset mid-transaction: IDLE and zero outputs on the following cycle; RAM contents retained.

## Timing
- Begin at cycle T. Read: first data_validOUT at T+2; beat k at T+2+k with busyIN low; end_transactionOUT one cycle after last transferred beat.
- Write: first beat may be accepted at T+1.
- Error: errorOUT and end_transactionOUT at T+1.
- Beat counter is 9 bits (max 256 beats).

## Configuration
- BUS_SRAM_WAIT_STATE_EN defined: busyOUT=1 in the first WRITE cycle (T+1, no beat accepted there), and READ_FETCH lasts two cycles (first data_validOUT at T+3). Used to exercise initiator stall handling.
- Undefined: busyOUT is constantly 0, timing as above.

## Structure
- Shared package bus_pkg: state enum, burst width (8), beat-count width (9), bus data width (32), byte-enable width (4).
- One sub-module: sram_be, single-port synchronous RAM, 1-cycle read latency, per-byte write enables, parameterised by depth.

## Test plan
- Write 0xDEADBEEF to BASE+0x10, burst 0, be 4'hF; read back -> data_validOUT at T+2 with 0xDEADBEEF, end_transactionOUT at T+3.
- Write burst 3 (4 beats 1..4) at BASE+0; read burst 3 with busyIN high on beat 2 for 3 cycles -> words 1,2,3,4 in order, beat 2 held stable.
- Write 0x11223344 be 4'hF then 0xAABBCCDD be 4'b0101 to same word; read -> 0x11BB33DD.
- Read at BASE+4*SIZE_WORDS -> errorOUT and end_transactionOUT high for exactly one cycle at T+1, no data_validOUT.
- Read burst 1 at last word -> second beat returns word 0 (wrap).
- system_reset asserted mid read burst -> all outputs 0 next cycle; subsequent read returns previously written data.
